// File: rtl/ahb2_pkg.sv
// AHB2 protocol encodings, slave FSM state type and lane/alignment helpers.
// Shared by the SRAM slave, its memory sub-module and the testbench.
package ahb2_pkg;

  localparam int unsigned HTRANS_W = 2;
  localparam int unsigned HRESP_W  = 2;
  localparam int unsigned HSIZE_W  = 3;
  localparam int unsigned HBURST_W = 3;
  localparam int unsigned HDATA_W  = 32;
  localparam int unsigned HBE_W    = HDATA_W / 8;
  localparam int unsigned WCNT_W   = 4;

  localparam logic [HTRANS_W-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [HTRANS_W-1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [HTRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [HTRANS_W-1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [HRESP_W-1:0] HRESP_OKAY  = 2'b00;
  localparam logic [HRESP_W-1:0] HRESP_ERROR = 2'b01;
  localparam logic [HRESP_W-1:0] HRESP_RETRY = 2'b10;
  localparam logic [HRESP_W-1:0] HRESP_SPLIT = 2'b11;

  localparam logic [HSIZE_W-1:0] HSIZE_BYTE = 3'b000;
  localparam logic [HSIZE_W-1:0] HSIZE_HALF = 3'b001;
  localparam logic [HSIZE_W-1:0] HSIZE_WORD = 3'b010;

  localparam logic [HBURST_W-1:0] HBURST_SINGLE = 3'b000;
  localparam logic [HBURST_W-1:0] HBURST_INCR   = 3'b001;
  localparam logic [HBURST_W-1:0] HBURST_WRAP4  = 3'b010;
  localparam logic [HBURST_W-1:0] HBURST_INCR4  = 3'b011;
  localparam logic [HBURST_W-1:0] HBURST_WRAP8  = 3'b100;
  localparam logic [HBURST_W-1:0] HBURST_INCR8  = 3'b101;
  localparam logic [HBURST_W-1:0] HBURST_WRAP16 = 3'b110;
  localparam logic [HBURST_W-1:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_ERR1 = 2'b10,
    S_ERR2 = 2'b11
  } state_e;

  // Little-endian byte lanes touched by a transfer of the given size/offset.
  function automatic logic [HBE_W-1:0] byte_en(input logic [HSIZE_W-1:0] size,
                                               input logic [1:0]         off);
    logic [HBE_W-1:0] be;
    be = '0;
    case (size)
      HSIZE_BYTE: be = HBE_W'(4'b0001 << off);
      HSIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

  // Transfers wider than the bus or not naturally aligned get an ERROR response.
  function automatic logic xfer_err(input logic [HSIZE_W-1:0] size,
                                    input logic [1:0]         off);
    logic err;
    err = 1'b0;
    if (size > HSIZE_WORD)                  err = 1'b1;
    if ((size == HSIZE_HALF) && off[0])     err = 1'b1;
    if ((size == HSIZE_WORD) && (off != '0)) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/ahb2_sram_slv_mem.sv
// Word-organised single-port memory with per-byte write enables.
// Ports: clk_i; addr_i word address; we_i/be_i/wdata_i synchronous write;
// rdata_o asynchronous read of addr_i. Contents are never reset.
module ahb2_sram_slv_mem
  import ahb2_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic               clk_i,
  input  logic [AW-1:0]      addr_i,
  input  logic               we_i,
  input  logic [HBE_W-1:0]   be_i,
  input  logic [HDATA_W-1:0] wdata_i,
  output logic [HDATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [HDATA_W-1:0] mem_q [DEPTH];

  // Byte-lane write.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < int'(HBE_W); b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb2_sram_slv.sv
// AHB2 slave fronting an on-chip SRAM: pipelined address/data phases,
// WAIT_CYCLES stall cycles per OKAY data phase, byte/half/word writes and
// the two-cycle ERROR response for oversized or misaligned transfers.
// Ports: hclk/hreset_n; AHB slave inputs hsel, haddr, htrans, hwrite, hsize,
// hburst (ignored), hprot (ignored), hwdata; outputs hrdata, hready, hresp.
module ahb2_sram_slv
  import ahb2_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                hclk,
  input  logic                hreset_n,
  input  logic                hsel,
  input  logic [31:0]         haddr,
  input  logic [HTRANS_W-1:0] htrans,
  input  logic                hwrite,
  input  logic [HSIZE_W-1:0]  hsize,
  input  logic [HBURST_W-1:0] hburst,
  input  logic [3:0]          hprot,
  input  logic [HDATA_W-1:0]  hwdata,
  output logic [HDATA_W-1:0]  hrdata,
  output logic                hready,
  output logic [HRESP_W-1:0]  hresp
);

  localparam int unsigned WA_W = ADDR_WIDTH - 2;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   cnt_q, cnt_d;
  logic                hready_q, hready_d;
  logic [HRESP_W-1:0]  hresp_q, hresp_d;
  logic                act_q, act_d;     // an OKAY data phase is in flight
  logic                write_q, write_d;
  logic [WA_W-1:0]     waddr_q, waddr_d;
  logic [HBE_W-1:0]    be_q, be_d;

  logic                accept_c;
  logic                done_c;
  logic                mem_we_c;
  logic [HDATA_W-1:0]  mem_rdata_c;
  logic                unused_c;

  assign unused_c = ^{hburst, hprot, haddr[31:ADDR_WIDTH]};

  assign accept_c = hready_q & hsel & htrans[1];
  // Data phase completes on any hready=1 cycle while an OKAY phase is active.
  assign done_c   = act_q & hready_q;
  assign mem_we_c = done_c & write_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hready_d = hready_q;
    hresp_d  = hresp_q;
    act_d    = act_q;
    write_d  = write_q;
    waddr_d  = waddr_q;
    be_d     = be_q;

    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = S_IDLE;
          hready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - WCNT_W'(1);
        end
      end
      S_ERR1: begin
        state_d  = S_ERR2;
        hready_d = 1'b1;
        hresp_d  = HRESP_ERROR;
      end
      default: begin
        // S_IDLE and S_ERR2 both present hready=1 and sample the address phase.
        state_d  = S_IDLE;
        hready_d = 1'b1;
        hresp_d  = HRESP_OKAY;
        act_d    = 1'b0;
        if (accept_c) begin
          write_d = hwrite;
          waddr_d = haddr[ADDR_WIDTH-1:2];
          be_d    = byte_en(hsize, haddr[1:0]);
          if (xfer_err(hsize, haddr[1:0])) begin
            state_d  = S_ERR1;
            hready_d = 1'b0;
            hresp_d  = HRESP_ERROR;
          end else begin
            act_d = 1'b1;
            if (WAIT_CYCLES != 0) begin
              state_d  = S_WAIT;
              hready_d = 1'b0;
              cnt_d    = WCNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
      act_q    <= 1'b0;
      write_q  <= 1'b0;
      waddr_q  <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      act_q    <= act_d;
      write_q  <= write_d;
      waddr_q  <= waddr_d;
      be_q     <= be_d;
    end
  end

  ahb2_sram_slv_mem #(
    .AW (WA_W)
  ) u_mem (
    .clk_i   (hclk),
    .addr_i  (waddr_q),
    .we_i    (mem_we_c),
    .be_i    (be_q),
    .wdata_i (hwdata),
    .rdata_o (mem_rdata_c)
  );

  assign hready = hready_q;
  assign hresp  = hresp_q;
  // Read data only in a completing read phase; zero otherwise.
  assign hrdata = (done_c && !write_q) ? mem_rdata_c : '0;

endmodule
